// File: rtl/mult_resource_arb.sv
// Round-robin, credit-limited sharing of one pipelined multiplier among NUM_IN requesters.
// Requests are tagged with the requester index on issue; results are steered back by that tag.
module mult_resource_arb #(
    parameter int NUM_IN      = 4,
    parameter int DAT_BITS    = 762,
    parameter int RES_BITS    = 381,
    parameter int CTL_BITS    = 10,
    parameter int OVR_WRT_BIT = 8,
    parameter int MAX_OUTST   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_IN-1:0]            i_req_val,
    output logic [NUM_IN-1:0]            o_req_rdy,
    input  logic [NUM_IN*DAT_BITS-1:0]   i_req_dat,
    input  logic [NUM_IN*CTL_BITS-1:0]   i_req_ctl,
    output logic                         o_mul_val,
    input  logic                         i_mul_rdy,
    output logic [DAT_BITS-1:0]          o_mul_dat,
    output logic [CTL_BITS-1:0]          o_mul_ctl,
    input  logic                         i_res_val,
    output logic                         o_res_rdy,
    input  logic [RES_BITS-1:0]          i_res_dat,
    input  logic [CTL_BITS-1:0]          i_res_ctl,
    output logic [NUM_IN-1:0]            o_rsp_val,
    input  logic [NUM_IN-1:0]            i_rsp_rdy,
    output logic [RES_BITS-1:0]          o_rsp_dat,
    output logic [CTL_BITS-1:0]          o_rsp_ctl,
    output logic [7:0]                   o_outst,
    output logic                         o_err
);

    localparam int IW = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;

    logic [IW-1:0]       rr_ptr, gnt_idx, cand, res_tag;
    logic                gnt_any, load_ok, credit_ok, req_at;
    logic                rsp_done, tag_ok, res_take;
    logic [DAT_BITS-1:0] sel_dat;
    logic [CTL_BITS-1:0] sel_ctl;
    logic [NUM_IN-1:0]   tag_onehot;

    // Search starts just after the last winner and wraps, so the first hit is the RR winner.
    always_comb begin
        load_ok   = ~o_mul_val | i_mul_rdy;
        credit_ok = o_outst < 8'(MAX_OUTST);
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        req_at    = 1'b0;
        sel_dat   = '0;
        sel_ctl   = '0;
        for (int i = 1; i <= NUM_IN; i++) begin
            cand   = IW'((int'(rr_ptr) + i) % NUM_IN);
            req_at = 1'b0;
            for (int k = 0; k < NUM_IN; k++)
                if (cand == IW'(k)) req_at = i_req_val[k];
            if (!gnt_any && load_ok && credit_ok && req_at) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        o_req_rdy = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (gnt_idx == IW'(k)) begin
                sel_dat = i_req_dat[k*DAT_BITS +: DAT_BITS];
                sel_ctl = i_req_ctl[k*CTL_BITS +: CTL_BITS];
            end
            o_req_rdy[k] = gnt_any && (gnt_idx == IW'(k));
        end
        sel_ctl[OVR_WRT_BIT +: IW] = gnt_idx;
    end

    always_comb begin
        res_tag   = i_res_ctl[OVR_WRT_BIT +: IW];
        tag_ok    = {1'b0, res_tag} < (IW+1)'(NUM_IN);
        rsp_done  = |(o_rsp_val & i_rsp_rdy);
        o_res_rdy = ~|o_rsp_val | rsp_done;
        res_take  = i_res_val & o_res_rdy;
        for (int k = 0; k < NUM_IN; k++)
            tag_onehot[k] = (res_tag == IW'(k));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_mul_val <= 1'b0;
            o_rsp_val <= '0;
            o_outst   <= '0;
            o_err     <= 1'b0;
            rr_ptr    <= IW'(NUM_IN - 1);
        end else begin
            if (gnt_any) begin
                o_mul_val <= 1'b1;
                rr_ptr    <= gnt_idx;
            end else if (load_ok) begin
                o_mul_val <= 1'b0;
            end

            // A grant and a delivery on the same edge cancel out.
            if (gnt_any && !rsp_done) begin
                o_outst <= o_outst + 8'd1;
            end else if (!gnt_any && rsp_done) begin
                if (o_outst == 8'd0) o_err <= 1'b1;
                else                 o_outst <= o_outst - 8'd1;
            end

            if (res_take) begin
                if (tag_ok) begin
                    o_rsp_val <= tag_onehot;
                end else begin
                    o_rsp_val <= '0;
                    o_err     <= 1'b1;
                end
            end else if (rsp_done) begin
                o_rsp_val <= '0;
            end
        end
    end

    // Payload registers carry no reset; they are qualified by the valids above.
    always_ff @(posedge i_clk) begin
        if (gnt_any) begin
            o_mul_dat <= sel_dat;
            o_mul_ctl <= sel_ctl;
        end
        if (res_take && tag_ok) begin
            o_rsp_dat <= i_res_dat;
            o_rsp_ctl <= i_res_ctl;
        end
    end

endmodule

// File: tb/tb_mult_resource_arb.sv
// Directed + randomized bench for mult_resource_arb with a transaction-level reference model.
module tb_mult_resource_arb;

    localparam int N    = 3;
    localparam int DW   = 16;
    localparam int RW   = 8;
    localparam int CW   = 10;
    localparam int OVR  = 8;
    localparam int MAXO = 6;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_val, req_rdy, rsp_val, rsp_rdy;
    logic [N*DW-1:0]   req_dat;
    logic [N*CW-1:0]   req_ctl;
    logic              mul_val, mul_rdy, res_val, res_rdy, err;
    logic [DW-1:0]     mul_dat;
    logic [CW-1:0]     mul_ctl, res_ctl, rsp_ctl;
    logic [RW-1:0]     res_dat, rsp_dat;
    logic [7:0]        outst;

    int checks = 0;
    int failures = 0;

    // Reference model state: what the outputs should be after the latest edge.
    logic          m_mul_val;
    logic [DW-1:0] m_mul_dat;
    logic [CW-1:0] m_mul_ctl, m_rsp_ctl;
    logic [RW-1:0] m_rsp_dat;
    int            m_rsp;
    int            m_outst;
    logic          m_err;
    int            m_last;

    mult_resource_arb #(
        .NUM_IN(N), .DAT_BITS(DW), .RES_BITS(RW), .CTL_BITS(CW),
        .OVR_WRT_BIT(OVR), .MAX_OUTST(MAXO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_val(req_val), .o_req_rdy(req_rdy), .i_req_dat(req_dat), .i_req_ctl(req_ctl),
        .o_mul_val(mul_val), .i_mul_rdy(mul_rdy), .o_mul_dat(mul_dat), .o_mul_ctl(mul_ctl),
        .i_res_val(res_val), .o_res_rdy(res_rdy), .i_res_dat(res_dat), .i_res_ctl(res_ctl),
        .o_rsp_val(rsp_val), .i_rsp_rdy(rsp_rdy), .o_rsp_dat(rsp_dat), .o_rsp_ctl(rsp_ctl),
        .o_outst(outst), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [CW-1:0] mk_ctl(input int tag);
        logic [CW-1:0] c;
        c = CW'($urandom());
        c[OVR +: IW] = IW'(tag);
        return c;
    endfunction

    task automatic rnd_req();
        req_dat = (N*DW)'({$urandom(), $urandom()});
        req_ctl = (N*CW)'($urandom());
        res_dat = RW'($urandom());
    endtask

    task automatic check_regs();
        chk("mul_val", 32'(mul_val), 32'(m_mul_val));
        if (m_mul_val) begin
            chk("mul_dat", 32'(mul_dat), 32'(m_mul_dat));
            chk("mul_ctl", 32'(mul_ctl), 32'(m_mul_ctl));
        end
        chk("rsp_val", 32'(rsp_val), (m_rsp >= 0) ? 32'(1 << m_rsp) : 32'd0);
        if (m_rsp >= 0) begin
            chk("rsp_dat", 32'(rsp_dat), 32'(m_rsp_dat));
            chk("rsp_ctl", 32'(rsp_ctl), 32'(m_rsp_ctl));
        end
        chk("outst", 32'(outst), 32'(m_outst));
        chk("err", 32'(err), 32'(m_err));
    endtask

    // One clock: check handshakes against the rules, advance the model, then check registers.
    task automatic step();
        int   g, t, k;
        logic lok, dlv, rrdy;
        #1;
        lok = !m_mul_val || mul_rdy;
        g = -1;
        if (lok && m_outst < MAXO)
            for (int i = 1; i <= N; i++) begin
                k = (m_last + i) % N;
                if (g < 0 && 1'(req_val >> k)) g = k;
            end
        dlv  = (m_rsp >= 0) && 1'(rsp_rdy >> m_rsp);
        rrdy = (m_rsp < 0) || dlv;
        chk("req_rdy", 32'(req_rdy), (g >= 0) ? 32'(1 << g) : 32'd0);
        chk("res_rdy", 32'(res_rdy), 32'(rrdy));

        if (g >= 0) begin
            m_mul_val = 1'b1;
            m_mul_dat = DW'(req_dat >> (g*DW));
            m_mul_ctl = CW'(req_ctl >> (g*CW));
            m_mul_ctl[OVR +: IW] = IW'(g);
            m_last = g;
        end else if (lok) begin
            m_mul_val = 1'b0;
        end
        if (g >= 0 && !dlv) m_outst++;
        else if (g < 0 && dlv) begin
            if (m_outst == 0) m_err = 1'b1;
            else m_outst--;
        end
        if (res_val && rrdy) begin
            t = int'(res_ctl[OVR +: IW]);
            if (t < N) begin
                m_rsp = t; m_rsp_dat = res_dat; m_rsp_ctl = res_ctl;
            end else begin
                m_rsp = -1; m_err = 1'b1;
            end
        end else if (dlv) begin
            m_rsp = -1;
        end
        @(posedge clk); #1;
        check_regs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_val = '0; res_val = 1'b0; mul_rdy = 1'b0; rsp_rdy = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_mul_val = 1'b0; m_rsp = -1; m_outst = 0; m_err = 1'b0; m_last = N - 1;
        check_regs();
    endtask

    initial begin
        rst_n = 1'b0; req_val = '0; rsp_rdy = '0; mul_rdy = 1'b0; res_val = 1'b0;
        req_dat = '0; req_ctl = '0; res_dat = '0; res_ctl = '0;
        m_mul_dat = '0; m_mul_ctl = '0; m_rsp_dat = '0; m_rsp_ctl = '0;
        do_reset();

        // Everyone requesting, multiplier always ready: grants rotate 0,1,2,0.
        mul_rdy = 1'b1; req_val = '1; rsp_rdy = '1;
        repeat (4) begin rnd_req(); step(); end

        // Multiplier stalls: held operands, no grant.
        mul_rdy = 1'b0;
        repeat (5) begin rnd_req(); step(); end
        chk("stall_outst", 32'(outst), 32'd4);

        // Run into the credit limit.
        mul_rdy = 1'b1;
        repeat (4) begin rnd_req(); step(); end
        chk("full_outst", 32'(outst), 32'(MAXO));
        chk("full_req_rdy", 32'(req_rdy), 32'd0);

        // One result back frees exactly one credit, which is reused.
        res_val = 1'b1; res_ctl = mk_ctl(1); res_dat = RW'($urandom()); step();
        res_val = 1'b0; step();
        step();
        chk("regrant_outst", 32'(outst), 32'(MAXO));

        // Requester 2 back-pressures its response; the return path stalls.
        req_val = '0; rsp_rdy = 3'b011;
        res_val = 1'b1; res_ctl = mk_ctl(2); res_dat = RW'($urandom()); step();
        res_ctl = mk_ctl(0); res_dat = RW'($urandom());
        repeat (3) step();
        chk("hold_rsp_val", 32'(rsp_val), 32'b100);
        chk("hold_res_rdy", 32'(res_rdy), 32'd0);
        rsp_rdy = '1; step();
        res_val = 1'b0; step();

        // Grant and delivery on the same edge at outst=5.
        req_val = 3'b001; rnd_req(); step();
        req_val = '0; res_val = 1'b1; res_ctl = mk_ctl(1); step();
        res_val = 1'b0; req_val = '1; rnd_req(); step();
        chk("same_edge_outst", 32'(outst), 32'd5);

        // Out-of-range tag is dropped and flagged.
        req_val = '0; res_val = 1'b1; res_ctl = mk_ctl(3); step();
        res_val = 1'b0;
        chk("bad_tag_err", 32'(err), 32'd1);
        chk("bad_tag_rsp", 32'(rsp_val), 32'd0);
        chk("bad_tag_outst", 32'(outst), 32'd5);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            req_val = N'($urandom());
            mul_rdy = ($urandom_range(0, 3) != 0);
            res_val = 1'($urandom());
            res_ctl = mk_ctl(int'($urandom_range(0, 3)));
            rsp_rdy = N'($urandom());
            rnd_req();
            step();
        end

        // Reset mid-stream, then a stale result underflows the credit counter.
        do_reset();
        chk("rst_outst", 32'(outst), 32'd0);
        chk("rst_mul_val", 32'(mul_val), 32'd0);
        mul_rdy = 1'b1; rsp_rdy = '1;
        res_val = 1'b1; res_ctl = mk_ctl(1); res_dat = RW'($urandom()); step();
        res_val = 1'b0; step();
        chk("underflow_err", 32'(err), 32'd1);
        chk("underflow_outst", 32'(outst), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
